// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_arbiter.
// slave = the arbiter; master = requesters plus the ALU instance.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    input  alu_a, alu_b, alu_control,
    output alu_result, alu_zero,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    output alu_a, alu_b, alu_control,
    input  alu_result, alu_zero,
    output busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between two requesters: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             grant;
  logic             accept;
  logic             owner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = ~bus.req0_valid & bus.req1_valid;
`else
  logic prio;

  // A lone requester always wins; prio only breaks ties.
  assign grant = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~grant;
    end
  end
`endif

  assign accept = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = accept ? EXEC : IDLE;
      EXEC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands are sampled only on the accept cycle and then held for the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      owner <= 1'b0;
    end else if (accept) begin
      a_q   <= grant ? bus.req1_a  : bus.req0_a;
      b_q   <= grant ? bus.req1_b  : bus.req0_b;
      op_q  <= grant ? bus.req1_op : bus.req0_op;
      owner <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (state == EXEC) begin
      result_q <= bus.alu_result;
      zero_q   <= bus.alu_zero;
    end
  end

  always_comb begin
    bus.req0_ready  = (state == IDLE) && !rst && !grant;
    bus.req1_ready  = (state == IDLE) && !rst && grant;
    bus.rsp0_valid  = (state == RESP) && !owner;
    bus.rsp1_valid  = (state == RESP) && owner;
    bus.busy        = (state != IDLE);
    bus.alu_a       = a_q;
    bus.alu_b       = b_q;
    bus.alu_control = op_q;
    bus.rsp_result  = result_q;
    bus.rsp_zero    = zero_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model with a behavioural ALU.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_control);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: an accept books the ALU for three cycles and
  // schedules a response two cycles later.
  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        zero;
    int          due;
  } txn_t;

  txn_t        q[$];
  int          cycle = 0;
  int          busy_until = -1;
  bit          started = 0;
  bit          m_prio = 0;
  logic [31:0] m_a = 0, m_b = 0, exp_result = 0;
  logic [3:0]  m_op = 0;
  logic        exp_zero = 0;

  task automatic model_clear();
    q.delete();
    busy_until = cycle;
    m_prio = 0;
    m_a = 0; m_b = 0; m_op = 0;
    exp_result = 0; exp_zero = 0;
  endtask

  always @(negedge clk) begin
    bit   idle, e_rsp0, e_rsp1;
    int   g;
    cycle++;
    if (!started) begin
      if (rst) begin
        started = 1;
        model_clear();
      end
    end else begin
      idle = (cycle > busy_until);
      e_rsp0 = 0;
      e_rsp1 = 0;
      if (q.size() > 0 && q[0].due == cycle) begin
        e_rsp0 = (q[0].owner == 0);
        e_rsp1 = (q[0].owner == 1);
        exp_result = q[0].res;
        exp_zero = q[0].zero;
        void'(q.pop_front());
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = (bus.req0_valid) ? 0 : (bus.req1_valid ? 1 : 0);
`else
      g = (bus.req0_valid && bus.req1_valid) ? int'(m_prio) : (bus.req1_valid ? 1 : 0);
`endif
      checkOutput("req0_ready", 32'(bus.req0_ready), 32'(!rst && idle && g == 0));
      checkOutput("req1_ready", 32'(bus.req1_ready), 32'(!rst && idle && g == 1));
      checkOutput("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_rsp0));
      checkOutput("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_rsp1));
      checkOutput("busy", 32'(bus.busy), 32'(!idle));
      checkOutput("rsp_result", bus.rsp_result, exp_result);
      checkOutput("rsp_zero", 32'(bus.rsp_zero), 32'(exp_zero));
      checkOutput("alu_a", bus.alu_a, m_a);
      checkOutput("alu_b", bus.alu_b, m_b);
      checkOutput("alu_control", 32'(bus.alu_control), 32'(m_op));
      if (rst) begin
        model_clear();
      end else if (idle && (bus.req0_valid || bus.req1_valid)) begin
        txn_t t;
        m_a  = (g == 1) ? bus.req1_a  : bus.req0_a;
        m_b  = (g == 1) ? bus.req1_b  : bus.req0_b;
        m_op = (g == 1) ? bus.req1_op : bus.req0_op;
        t.owner = g;
        t.res   = ref_alu(m_a, m_b, m_op);
        t.zero  = (t.res == 32'd0);
        t.due   = cycle + 2;
        q.push_back(t);
        busy_until = cycle + 2;
        m_prio = (g == 0);
      end
    end
  end

  // Holds the request until accepted; returns aligned to posedge+1 of the EXEC cycle.
  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, output int waited);
    bit done = 0;
    waited = 0;
    if (port == 0) begin
      bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
    while (!done && waited < 20) begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready : bus.req1_ready) done = 1;
      else waited++;
      @(posedge clk); #1;
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: port %0d not accepted within 20 cycles", port);
    end
  endtask

  // Called at posedge+1 of EXEC; checks the response in RESP, returns at posedge+1 of IDLE.
  task automatic wait_rsp(input string name, input int owner, input logic [31:0] res,
                          input logic zero);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "_rsp0"}, 32'(bus.rsp0_valid), 32'(owner == 0));
    checkOutput({name, "_rsp1"}, 32'(bus.rsp1_valid), 32'(owner == 1));
    checkOutput({name, "_result"}, bus.rsp_result, res);
    checkOutput({name, "_zero"}, 32'(bus.rsp_zero), 32'(zero));
    @(posedge clk); #1;
  endtask

  initial begin
    int          waited;
    int          grants[$];
    bit          acc0, acc1;
    logic [3:0]  ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_result", bus.rsp_result, 32'd0);
    @(posedge clk); #1;

    // 1: req0 ADD 5+7
    applyStimulus(0, 32'd5, 32'd7, 4'b0010, waited);
    checkOutput("t1_wait", 32'(waited), 32'd0);
    wait_rsp("t1", 0, 32'd12, 1'b0);

    // 2: req1 SUB 9-9
    applyStimulus(1, 32'd9, 32'd9, 4'b0110, waited);
    wait_rsp("t2", 1, 32'd0, 1'b1);

    // 3: both requesters continuously valid
    bus.req0_valid = 1; bus.req0_a = 32'hF0; bus.req0_b = 32'h0F; bus.req0_op = 4'b0001;
    bus.req1_valid = 1; bus.req1_a = 32'd3;  bus.req1_b = 32'd4;  bus.req1_op = 4'b0111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
      if (bus.rsp0_valid) checkOutput("t3_res0", bus.rsp_result, 32'hFF);
      if (bus.rsp1_valid) checkOutput("t3_res1", bus.rsp_result, 32'd1);
      @(posedge clk); #1;
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    checkOutput("t3_ngrants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      checkOutput("t3_grant", 32'(grants[i]), 32'd0);
`else
      checkOutput("t3_grant", 32'(grants[i]), 32'(i % 2));
`endif
    end

    // 4: req0 arrives while the ALU is busy with req1
    applyStimulus(1, 32'd1, 32'd2, 4'b0010, waited);
    bus.req0_valid = 1; bus.req0_a = 32'hF0F0; bus.req0_b = 32'hFF00; bus.req0_op = 4'b0000;
    @(negedge clk);
    checkOutput("t4_ready_exec", 32'(bus.req0_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4_ready_resp", 32'(bus.req0_ready), 32'd0);
    checkOutput("t4_rsp1_result", bus.rsp_result, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4_ready_idle", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    wait_rsp("t4", 0, 32'h0000F000, 1'b0);

    // 5: reset in EXEC drops the operation
    applyStimulus(0, 32'd0, 32'd0, 4'b1100, waited);
    rst = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_rsp0", 32'(bus.rsp0_valid), 32'd0);
    checkOutput("t5_result", bus.rsp_result, 32'd0);
    @(posedge clk); #1;

    // 6: unknown op still produces a response
    applyStimulus(0, 32'd1, 32'd1, 4'b1111, waited);
    wait_rsp("t6", 0, 32'd0, 1'b1);

    // Random traffic; a pending request keeps its operands until accepted.
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!(bus.req0_valid && !acc0)) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_a  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        bus.req0_b  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        bus.req0_op = ops[$urandom_range(0, 7)];
      end
      if (!(bus.req1_valid && !acc1)) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_a  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        bus.req1_b  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        bus.req1_op = ops[$urandom_range(0, 7)];
      end
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
    end
    rst = 0;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
